// File: rtl/systolic_skew_feeder_if.sv
// Stream/status bundle between the row-side operand feeder and its neighbours.
// master = the side that supplies vectors and job requests; slave = the feeder.
interface systolic_skew_feeder_if #(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int CNTW  = 8
);
  logic                  start;
  logic [CNTW-1:0]       len;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_data;
  logic [LANES*DW-1:0]   out_data;
  logic [LANES-1:0]      out_vld;
  logic                  busy;
  logic                  done;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, out_data, out_vld, busy, done
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, out_data, out_vld, busy, done
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Row-side operand feeder for the systolic MAC array.
// Accepts K vectors of LANES elements and drives lane i into array row i
// delayed by i extra cycles (diagonal wavefront), then flushes zeros so every
// lane drains and pulses done. Outputs never stall; input gaps become bubbles.
// Optional build macro FEEDER_PERF_EN adds the bubble_cnt output, counting
// LOAD cycles without an offered vector (cleared at job start, saturating).
module systolic_skew_feeder #(
  parameter int LANES = 4,
  parameter int DW    = 32,
  parameter int CNTW  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_skew_feeder_if.slave bus
`ifdef FEEDER_PERF_EN
  ,
  output logic [CNTW-1:0]      bubble_cnt
`endif
);

  // Flush down-counter must hold LANES-1.
  localparam int FW = $clog2(LANES) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t              state_reg, state_next;
  logic [CNTW-1:0]     len_reg, len_next;
  logic [CNTW-1:0]     cnt_reg, cnt_next;
  logic [FW-1:0]       flush_reg, flush_next;

  // Value entering stage 0 of every lane chain this cycle.
  logic                inject_vld;
  logic [LANES*DW-1:0] inject_data;

  logic [LANES*DW-1:0] out_data_w;
  logic [LANES-1:0]    out_vld_w;

  // State and job counters; async clear returns the feeder to IDLE at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      flush_reg <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      flush_reg <= flush_next;
    end
  end

  // Next-state logic and selection of what is injected into the chains.
  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    cnt_next    = cnt_reg;
    flush_next  = flush_reg;
    inject_vld  = 1'b0;
    inject_data = '0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            state_next = LOAD;
            len_next   = bus.len;
            cnt_next   = '0;
          end else begin
            // Empty job: nothing to skew, report completion right away.
            state_next = DONE;
          end
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          inject_vld  = 1'b1;
          inject_data = bus.in_data;
          cnt_next    = cnt_reg + CNTW'(1);
          // Full-width compare: len of all-ones never wraps the counter.
          if (cnt_next == len_reg) begin
            state_next = FLUSH;
            flush_next = FW'(LANES - 1);
          end
        end
      end
      FLUSH: begin
        // Lane LANES-1 needs LANES-1 extra shifts to drain its last element.
        flush_next = flush_reg - FW'(1);
        if (flush_reg == FW'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Per-lane delay lines; lane gi is gi+1 registers deep including the output.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DW-1:0] data_sr [gi+1];
    logic [gi:0]   vld_sr;

    // Shift one stage per clock in every state; never stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j <= gi; j++) begin
          data_sr[j] <= '0;
        end
        vld_sr <= '0;
      end else begin
        data_sr[0] <= inject_data[gi*DW +: DW];
        vld_sr[0]  <= inject_vld;
        for (int j = 1; j <= gi; j++) begin
          data_sr[j] <= data_sr[j-1];
          vld_sr[j]  <= vld_sr[j-1];
        end
      end
    end

    assign out_data_w[gi*DW +: DW] = data_sr[gi];
    assign out_vld_w[gi]           = vld_sr[gi];
  end

  assign bus.out_data = out_data_w;
  assign bus.out_vld  = out_vld_w;
  assign bus.in_ready = (state_reg == LOAD);
  assign bus.busy     = (state_reg == LOAD) || (state_reg == FLUSH);
  assign bus.done     = (state_reg == DONE);

`ifdef FEEDER_PERF_EN
  logic [CNTW-1:0] bubble_reg;

  // Count LOAD cycles with no vector offered; held after the job ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_reg <= '0;
    end else if ((state_reg == IDLE) && bus.start) begin
      bubble_reg <= '0;
    end else if ((state_reg == LOAD) && !bus.in_valid && (bubble_reg != '1)) begin
      bubble_reg <= bubble_reg + CNTW'(1);
    end
  end

  assign bubble_cnt = bubble_reg;
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: a job-level model records every
// injected vector by cycle and predicts each lane as that history delayed by
// lane+1 cycles; directed jobs pin the model with hand-computed values.
module tb_systolic_skew_feeder;
  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int CNTW  = 8;
  localparam int HN    = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  systolic_skew_feeder_if #(.LANES(LANES), .DW(DW), .CNTW(CNTW)) bus ();

`ifdef FEEDER_PERF_EN
  logic [CNTW-1:0] bubble_cnt;
`endif

  systolic_skew_feeder #(.LANES(LANES), .DW(DW), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef FEEDER_PERF_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  bit                  m_active = 1'b0;
  int                  m_remaining = 0;
  int                  m_done = -1;
  int                  m_bub = 0;
  int                  floor_c = 0;
  logic [LANES*DW-1:0] hist_d [HN];
  bit                  hist_v [HN];

  // DUT traces for the literal checks
  logic [DW-1:0] tr_l0 [HN];
  logic [DW-1:0] tr_l3 [HN];
  logic          tr_v0 [HN];
  logic          tr_done [HN];
  logic          tr_busy [HN];
  logic          tr_ready [HN];

  int last_acc = 0;

  task automatic chk(input string name, input logic [LANES*DW-1:0] act,
                     input logic [LANES*DW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, then model update from inputs.
  always @(negedge clk) begin : cmp
    logic [LANES*DW-1:0] e_data;
    logic [LANES*DW-1:0] inj_d;
    logic [LANES-1:0]    e_vld;
    bit idle, e_ready, e_done, e_busy, inj_v;
    int idx;
    if (cyc >= HN) begin
      $display("FAIL cycle_budget: cycle %0d actual=over required=under %0d", cyc, HN);
      $fatal(1);
    end
    tr_l0[cyc]    = bus.out_data[DW-1:0];
    tr_l3[cyc]    = bus.out_data[(LANES-1)*DW +: DW];
    tr_v0[cyc]    = bus.out_vld[0];
    tr_done[cyc]  = bus.done;
    tr_busy[cyc]  = bus.busy;
    tr_ready[cyc] = bus.in_ready;
    if (rst) begin
      chk("rst_out_data", bus.out_data, '0);
      chk("rst_out_vld", bus.out_vld, '0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
`ifdef FEEDER_PERF_EN
      chk("rst_bubble", bubble_cnt, 0);
`endif
      m_active    = 1'b0;
      m_remaining = 0;
      m_done      = -1;
      m_bub       = 0;
      floor_c     = cyc + 1;
      hist_d[cyc] = '0;
      hist_v[cyc] = 1'b0;
    end else begin
      idle    = !m_active && (cyc != m_done);
      e_ready = m_active && (m_remaining > 0);
      e_done  = (cyc == m_done);
      e_busy  = m_active && !e_done;
      e_data  = '0;
      e_vld   = '0;
      for (int i = 0; i < LANES; i++) begin
        idx = cyc - i - 1;
        if (idx >= floor_c) begin
          e_data[i*DW +: DW] = hist_d[idx][i*DW +: DW];
          e_vld[i]           = hist_v[idx];
        end
      end
      chk("out_data", bus.out_data, e_data);
      chk("out_vld", bus.out_vld, e_vld);
      chk("in_ready", bus.in_ready, e_ready);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
`ifdef FEEDER_PERF_EN
      chk("bubble_cnt", bubble_cnt, m_bub);
`endif
      inj_d = '0;
      inj_v = 1'b0;
      if (idle && bus.start) begin
        m_bub = 0;
        if (bus.len != 0) begin
          m_active    = 1'b1;
          m_remaining = int'(bus.len);
          m_done      = -1;
        end else begin
          m_done = cyc + 1;
        end
      end else if (e_ready) begin
        if (bus.in_valid) begin
          inj_d = bus.in_data;
          inj_v = 1'b1;
          m_remaining--;
          if (m_remaining == 0) m_done = cyc + LANES;
        end else if (m_bub != (1 << CNTW) - 1) begin
          m_bub++;
        end
      end
      if (e_done) m_active = 1'b0;
      hist_d[cyc] = inj_d;
      hist_v[cyc] = inj_v;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*DW-1:0] mkvec(input int k);
    logic [LANES*DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = DW'(LANES * k + i + 1);
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] rnd_vec();
    logic [LANES*DW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic start_job(input int l);
    bus.start = 1'b1;
    bus.len   = CNTW'(l);
    next_cycle();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int pct);
    int g = 0;
    while (m_active && (m_remaining > 0) && (g < 4000)) begin
      bus.in_valid = ($urandom_range(99) >= pct);
      bus.in_data  = rnd_vec();
      if (bus.in_valid) last_acc = cyc;
      next_cycle();
      g++;
    end
    bus.in_valid = 1'b0;
    if (g >= 4000) begin
      n_assert++;
      n_fail++;
      $display("FAIL feed_bound: actual=expired required=all accepted");
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while ((m_active || (m_done >= cyc)) && (g < 2000)) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.in_data  = rnd_vec();
      next_cycle();
      g++;
    end
    bus.in_valid = 1'b0;
    if (g >= 2000) begin
      n_assert++;
      n_fail++;
      $display("FAIL done_bound: actual=expired required=done");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int t0;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) next_cycle();
    rst = 1'b0;
    next_cycle();
    chk("idle_ready", bus.in_ready, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_vld", bus.out_vld, 0);

    // Consecutive len=3 job.
    start_job(3);
    t0 = cyc;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = mkvec(k);
      next_cycle();
    end
    bus.in_valid = 1'b0;
    wait_done();
    chk("t1_l0_1", tr_l0[t0+1], 1);
    chk("t1_l0_5", tr_l0[t0+2], 5);
    chk("t1_l0_9", tr_l0[t0+3], 9);
    chk("t1_l3_4", tr_l3[t0+4], 4);
    chk("t1_l3_8", tr_l3[t0+5], 8);
    chk("t1_l3_12", tr_l3[t0+6], 12);
    chk("t1_done", tr_done[t0+6], 1);
    chk("t1_busy", tr_busy[t0+6], 0);

    // Same job with a 2-cycle gap and an ignored start(len=7) during LOAD.
    start_job(3);
    t0 = cyc;
    bus.in_valid = 1'b1; bus.in_data = mkvec(0); next_cycle();
    bus.in_valid = 1'b1; bus.in_data = mkvec(1);
    bus.start = 1'b1; bus.len = CNTW'(7); next_cycle();
    bus.start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = rnd_vec(); next_cycle();
    next_cycle();
    bus.in_valid = 1'b1; bus.in_data = mkvec(2); next_cycle();
    bus.in_valid = 1'b0;
    wait_done();
    chk("t2_l0_a", {tr_v0[t0+1], tr_l0[t0+1]}, {1'b1, 32'd1});
    chk("t2_l0_b", {tr_v0[t0+2], tr_l0[t0+2]}, {1'b1, 32'd5});
    chk("t2_l0_c", {tr_v0[t0+3], tr_l0[t0+3]}, {1'b0, 32'd0});
    chk("t2_l0_d", {tr_v0[t0+4], tr_l0[t0+4]}, {1'b0, 32'd0});
    chk("t2_l0_e", {tr_v0[t0+5], tr_l0[t0+5]}, {1'b1, 32'd9});
    chk("t2_done_late", tr_done[t0+8], 1);
    chk("t2_no_early_done", tr_done[t0+6], 0);
`ifdef FEEDER_PERF_EN
    chk("t2_bubble", bubble_cnt, 2);
`endif

    // Empty job.
    start_job(0);
    t0 = cyc;
    wait_done();
    chk("t3_done", tr_done[t0], 1);
    chk("t3_ready", tr_ready[t0], 0);

    // Reset mid-LOAD after 2 of 5 accepts, then a normal len=3 job.
    start_job(5);
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = rnd_vec();
      next_cycle();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4_data", bus.out_data, '0);
    chk("t4_vld", bus.out_vld, '0);
    chk("t4_busy", bus.busy, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    next_cycle();
    start_job(3);
    feed(30);
    wait_done();

    // Maximum length, continuous valid.
    start_job(255);
    feed(0);
    wait_done();
    chk("t5_ready_last", tr_ready[last_acc], 1);
    chk("t5_ready_drop", tr_ready[last_acc+1], 0);
    chk("t5_done", tr_done[last_acc+LANES], 1);

    // Random back-to-back jobs.
    for (int j = 0; j < 25; j++) begin
      start_job(($urandom_range(9) == 0) ? 0 : $urandom_range(1, 12));
      feed($urandom_range(60));
      wait_done();
    end

    repeat (LANES + 2) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream operand feeder for one edge (row side) of the systolic MAC array.
- Accepts K parallel vectors of LANES elements over a valid/ready stream and drives lane i into the first PE of array row i, delayed by i extra cycles. This produces the diagonal wavefront the array needs.
- After the last vector it flushes zeros so every lane drains, then pulses done.
- PEs are free-running (no enable), so the feeder never stalls its outputs. Input gaps become zero bubbles.

Parameters:
- LANES, 4, number of array rows / output lanes (>=2).
- DW, 32, element width, matches PE operand width.
- CNTW, 8, width of the vector-count register; K max = 2^CNTW-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a job; sampled only in IDLE.
- len  in  CNTW  number of vectors K for the job; captured with start.
- in_valid  in  1  in_data holds a valid vector.
- in_ready  out  1  feeder accepts a vector this cycle.
- in_data  in  LANES*DW  vector; lane i = bits [i*DW +: DW].
- out_data  out  LANES*DW  skewed lane data to array row inputs.
- out_vld  out  LANES  per-lane flag: out_data lane i carries a real (non-bubble, non-flush) element.
- busy  out  1  high in LOAD and FLUSH.
- done  out  1  one-cycle pulse when the job's last element has left lane LANES-1.

Behaviour:
- Reset (async, any state): state=IDLE; all skew registers, out_data, out_vld, in_ready, busy, done = 0; counters = 0.
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - in_ready=0; skew chains shift zeros.
  - start=1 with len!=0 -> LOAD; latch len.
  - start=1 with len==0 -> DONE directly.
- LOAD:
  - in_ready=1 every cycle.
  - A cycle with in_valid=1 is an accept: the vector enters the chains with vld=1, and the accept count increments.
  - A cycle with in_valid=0 injects a zero vector with vld=0, uncounted.
  - On the accept that makes count==len -> FLUSH; in_ready drops in the next cycle.
- FLUSH:
  - in_ready=0; zeros with vld=0 are injected for exactly LANES-1 cycles (down-counter), then -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE.
- start outside IDLE is ignored.
- Skew:
  - Lane i is an (i+1)-deep register chain (data+vld), including the output register.
  - Latency from accept to out_data lane i = i+1 cycles.
  - Chains shift every clock in every state, never stalled.
- Timing: if the last accept is in cycle T, lane LANES-1 presents it in cycle T+LANES, and done is high in cycle T+LANES.
- Arithmetic: no arithmetic on data; pure delay. Counter compare is on the full CNTW width.
- Back-to-back: start may be asserted in the cycle after done (IDLE). The new job's first element may follow the previous job's tail with no overlap hazard.
- Reset mid-job: all in-flight elements are discarded, outputs are zero the same cycle, and the FSM returns to IDLE.

Optional Feature:
- Macro FEEDER_PERF_EN.
- Defined:
  - Adds output bubble_cnt [CNTW-1:0]: counts LOAD cycles with in_valid=0.
  - Cleared on rst and on a start accepted in IDLE; saturates at all-ones; holds its value after the job.
- Undefined: port absent, no counter logic.

Test Plan:
- rst asserted mid-LOAD after 2 of 5 accepts -> out_data=0, out_vld=0, busy=0 immediately; a subsequent start/len=3 job runs normally.
- LANES=4, start with len=3, vectors accepted in consecutive cycles T..T+2:
  - Vector 0 = {4,3,2,1} (lanes 3..0), vector 1 = {8,7,6,5}, vector 2 = {12,11,10,9}.
  - Lane 0 shows 1,5,9 at T+1..T+3; lane 3 shows 4,8,12 at T+4..T+6.
  - done=1 at T+6; busy=0 at T+6.
- Same job with in_valid low for 2 cycles between vectors 1 and 2 -> lane 0 shows 1,5,0,0,9 with out_vld=1,1,0,0,1; done 2 cycles later than the previous case; bubble_cnt=2 if FEEDER_PERF_EN.
- start with len=0 -> done pulses next cycle, in_ready never rises, out_vld stays 0.
- start pulsed again during LOAD with len=7 -> ignored; the job finishes after the original len accepts.
- len=255 (CNTW=8), continuous valid -> exactly 255 accepts, in_ready drops after the 255th; done 4 cycles after the last accept; no counter wrap.
